// File: rtl/izh_pkg.sv
// Shared definitions for the Izhikevich neuron datapath (state update, calc_dv, calc_dw).
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package izh_pkg;

    localparam int IZH_N     = 32;   // total word width, bit N-1 is the sign
    localparam int IZH_Q     = 16;   // fractional bits
    localparam int IZH_CNT_W = 16;   // step counter width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Sign-magnitude constants, Q16.
    localparam logic [IZH_N-1:0] IZH_V_INIT  = 32'h8041_0000;  // -65.0
    localparam logic [IZH_N-1:0] IZH_W_INIT  = 32'h800D_0000;  // -13.0
    localparam logic [IZH_N-1:0] IZH_V_TH    = 32'h001E_0000;  // +30.0
    localparam logic [IZH_N-1:0] IZH_V_RESET = 32'h8041_0000;  // c = -65.0
    localparam logic [IZH_N-1:0] IZH_D_INC   = 32'h0008_0000;  // d = +8.0

    // Signed a >= b on sign-magnitude words. A negative sign with a zero
    // magnitude is folded to +0 so that +0 == -0.
    function automatic logic sm_ge(input logic [IZH_N-1:0] a, input logic [IZH_N-1:0] b);
        logic             a_neg;
        logic             b_neg;
        logic [IZH_N-2:0] ma;
        logic [IZH_N-2:0] mb;
        ma    = a[IZH_N-2:0];
        mb    = b[IZH_N-2:0];
        a_neg = a[IZH_N-1] & (|ma);
        b_neg = b[IZH_N-1] & (|mb);
        if (a_neg != b_neg) begin
            sm_ge = b_neg;          // the non-negative operand is greater
        end else if (!a_neg) begin
            sm_ge = (ma >= mb);
        end else begin
            sm_ge = (ma <= mb);     // among negatives the smaller magnitude wins
        end
    endfunction

endpackage

// File: rtl/sm_add_sat.sv
// Sign-magnitude saturating adder; -0 inputs are read as +0 and -0 is never produced.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b (N-bit sign-magnitude operands), y (N-bit saturated sum).
module sm_add_sat #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    logic [N-2:0] ma;
    logic [N-2:0] mb;
    logic         sa;
    logic         sb;
    logic [N-1:0] mag_sum;   // one extra bit to catch magnitude overflow
    logic [N-2:0] mag;
    logic         sgn;

    always_comb begin
        ma      = a[N-2:0];
        mb      = b[N-2:0];
        sa      = a[N-1] & (|ma);
        sb      = b[N-1] & (|mb);
        mag_sum = {1'b0, ma} + {1'b0, mb};
        mag     = '0;
        sgn     = 1'b0;
        if (sa == sb) begin
            // Same sign: magnitudes add, clamp to full scale on carry-out.
            sgn = sa;
            mag = mag_sum[N-1] ? {(N-1){1'b1}} : mag_sum[N-2:0];
        end else if (ma >= mb) begin
            sgn = sa;
            mag = ma - mb;
        end else begin
            sgn = sb;
            mag = mb - ma;
        end
        // A zero result always comes out as +0.
        y = {sgn & (|mag), mag};
    end

endmodule

// File: rtl/izh_state_update.sv
// Izhikevich neuron state register/integrator: v += dv, w += dw, then spike check and reset.
// Latency: done pulses 2 edges after start is accepted; one step every 3 cycles back-to-back.
// Backpressure: start is accepted only in IDLE; start while busy is dropped, not queued.
// Ports: clk, rst_n (sync, active low), start, dv_in, dw_in -> v_out, w_out, busy, done,
//        spike, step_count.
module izh_state_update
    import izh_pkg::*;
#(
    parameter int           N       = IZH_N,
    parameter int           CNT_W   = IZH_CNT_W,
    parameter logic [N-1:0] V_INIT  = IZH_V_INIT,
    parameter logic [N-1:0] W_INIT  = IZH_W_INIT,
    parameter logic [N-1:0] V_TH    = IZH_V_TH,
    parameter logic [N-1:0] V_RESET = IZH_V_RESET,
    parameter logic [N-1:0] D_INC   = IZH_D_INC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N-1:0]     dv_in,
    input  logic [N-1:0]     dw_in,
    output logic [N-1:0]     v_out,
    output logic [N-1:0]     w_out,
    output logic             busy,
    output logic             done,
    output logic             spike,
    output logic [CNT_W-1:0] step_count
);

    state_t         state;
    state_t         state_nxt;
    logic           load_d;
    logic           do_add;
    logic           do_check;

    logic [N-1:0]   v_r;
    logic [N-1:0]   w_r;
    logic [N-1:0]   dv_r;
    logic [N-1:0]   dw_r;
    logic [N-1:0]   v_sum;
    logic [N-1:0]   w_sum;
    logic [N-1:0]   w_spk;
    logic           v_hit;
    logic           done_r;
    logic           spike_r;
    logic [CNT_W-1:0] cnt_r;

    sm_add_sat #(.N(N)) u_add_v (.a(v_r), .b(dv_r),  .y(v_sum));
    sm_add_sat #(.N(N)) u_add_w (.a(w_r), .b(dw_r),  .y(w_sum));
    sm_add_sat #(.N(N)) u_add_d (.a(w_r), .b(D_INC), .y(w_spk));

    // In CHECK, v_r already holds the integrated value written at the ADD edge.
    assign v_hit = sm_ge(v_r, V_TH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_d    = 1'b0;
        do_add    = 1'b0;
        do_check  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_d    = 1'b1;
                    state_nxt = ADD;
                end
            end
            ADD: begin
                do_add    = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                do_check  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_r     <= V_INIT;
            w_r     <= W_INIT;
            dv_r    <= '0;
            dw_r    <= '0;
            done_r  <= 1'b0;
            spike_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            done_r  <= 1'b0;
            spike_r <= 1'b0;
            if (load_d) begin
                dv_r <= dv_in;
                dw_r <= dw_in;
            end
            if (do_add) begin
                v_r <= v_sum;
                w_r <= w_sum;
            end
            if (do_check) begin
                if (v_hit) begin
                    v_r     <= V_RESET;
                    w_r     <= w_spk;
                    spike_r <= 1'b1;
                end
                done_r <= 1'b1;
                cnt_r  <= cnt_r + 1'b1;
            end
        end
    end

    assign v_out      = v_r;
    assign w_out      = w_r;
    assign busy       = (state != IDLE);
    assign done       = done_r;
    assign spike      = spike_r;
    assign step_count = cnt_r;

endmodule
